// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline-stage buffer.
//   word_t        : default machine word (sets the default payload width)
//   pbuf_state_t  : buffer fill state; the encoding equals the entry count
//   pbuf_occupancy: maps a state to its entry count (0..2)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pbuf_state_t;

    function automatic logic [1:0] pbuf_occupancy(input pbuf_state_t s);
        return logic'(s) == 1'b0 ? {1'b0, 1'b0} | 2'(s) : 2'(s);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the buffer statistics.
//   CLK      : rising-edge clock
//   RST      : asynchronous active-high reset, count -> 0
//   clear    : synchronous clear, wins over increment
//   inc_amt  : amount to add this cycle (0..3)
//   count    : current value, sticks at 2^CW-1
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clear,
    input  logic [1:0]    inc_amt,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [CW:0]   sum;

    // One extra bit catches the overflow; since inc_amt <= 3 and the
    // counter never exceeds its maximum, a carry means "past the top".
    always_comb begin
        sum        = {1'b0, count_reg} + (CW+1)'(inc_amt);
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (sum[CW]) begin
            count_next = '1;
        end else begin
            count_next = sum[CW-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages with load-use hold
// (bubble), branch squash (flush) and saturating statistics.
//   CLK, RST    : clock, asynchronous active-high reset
//   in_valid/in_data/in_ready    : upstream handshake
//   out_valid/out_data/out_ready : downstream handshake (out_data = NOP_VAL when empty)
//   bubble      : block intake this cycle, popping still allowed
//   flush       : discard all entries and the word offered this cycle
//   occupancy   : entries held (0..2)
//   bubble_cnt  : cycles with bubble=1 (saturating)
//   drop_cnt    : entries discarded by flush (saturating)
module pipe_stage_buf
    import cpu_types_pkg::*;
#(
    parameter int            DW      = $bits(word_t),
    parameter logic [DW-1:0] NOP_VAL = '0,
    parameter int            CW      = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    input  logic          bubble,
    input  logic          flush,
    output logic [1:0]    occupancy,
    output logic [CW-1:0] bubble_cnt,
    output logic [CW-1:0] drop_cnt
);

    pbuf_state_t   state_reg, state_next;
    logic [DW-1:0] head_reg, head_next;
    logic [DW-1:0] skid_reg, skid_next;
    logic          accept;
    logic          pop;
    logic [1:0]    drop_inc;

    // in_ready depends only on registered state and the local hold/squash
    // inputs, so no combinational path runs from out_ready to in_ready.
    assign in_ready  = (state_reg != FULL) & ~bubble & ~flush;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = out_valid ? head_reg : NOP_VAL;
    assign occupancy = pbuf_occupancy(state_reg);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign drop_inc  = flush ? occupancy : 2'd0;

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        if (flush) begin
            // Stale payloads may remain in head/skid; out_data masks them.
            state_next = EMPTY;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        head_next  = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_next = in_data;
                    end else if (accept) begin
                        state_next = FULL;
                        skid_next  = in_data;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next = ONE;
                        head_next  = skid_reg;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= EMPTY;
            head_reg  <= NOP_VAL;
            skid_reg  <= NOP_VAL;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
        end
    end

    sat_counter #(.CW(CW)) u_bubble_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (1'b0),
        .inc_amt ({1'b0, bubble}),
        .count   (bubble_cnt)
    );

    sat_counter #(.CW(CW)) u_drop_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (1'b0),
        .inc_amt (drop_inc),
        .count   (drop_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf. A second instance with CW=2 and
// a non-zero NOP_VAL shares the stimulus to exercise saturation and the
// empty-output value.
module tb_pipe_stage_buf;

    localparam logic [31:0] NOP2 = 32'hDEAD_BEEF;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        bubble;
    logic        flush;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] bubble_cnt, drop_cnt;

    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  bubble_cnt2, drop_cnt2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    int          mbub;
    int          mdrop;

    pipe_stage_buf #(.DW(32), .NOP_VAL(32'h0), .CW(16)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .bubble(bubble), .flush(flush),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt), .drop_cnt(drop_cnt)
    );

    pipe_stage_buf #(.DW(32), .NOP_VAL(NOP2), .CW(2)) dut2 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready), .bubble(bubble), .flush(flush),
        .occupancy(occupancy2), .bubble_cnt(bubble_cnt2), .drop_cnt(drop_cnt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Advances one clock edge and applies the reference FIFO behaviour.
    task automatic step();
        bit acc, pp;
        acc = in_valid && (exp_q.size() < 2) && !bubble && !flush;
        pp  = (exp_q.size() != 0) && out_ready;
        @(posedge CLK);
        if (flush) begin
            $display("flush dropped=%0d", exp_q.size());
            mdrop += exp_q.size();
            exp_q.delete();
        end else begin
            if (pp) $display("pop  data=%h", exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(in_data);
                $display("acc  data=%h", in_data);
            end
        end
        if (bubble) mbub++;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; in_valid = 1'b1; in_data = 32'h77;
        out_ready = 1'b0; bubble = 1'b0; flush = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (out_data2 !== NOP2) begin failures++; $display("FAIL rst_out_data2 got=%h exp=%h", out_data2, NOP2); end
        checks++; if (bubble_cnt !== 16'd0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", bubble_cnt, drop_cnt); end
        RST = 1'b0; in_valid = 1'b0;
        exp_q.delete(); mbub = 0; mdrop = 0;
    endtask

    task automatic test_fill();
        int exp_occ[3] = '{1, 2, 2};
        in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (occupancy !== 2'(exp_occ[i]) || occupancy !== 2'(exp_q.size())) begin failures++; $display("FAIL fill_occ[%0d] got=%0d exp=%0d", i, occupancy, exp_occ[i]); end
            checks++; if (out_data !== 32'h1234) begin failures++; $display("FAIL fill_data[%0d] got=%h exp=1234", i, out_data); end
            checks++; if (in_ready !== (i == 0)) begin failures++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, (i == 0)); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3 && exp_q.size() != 0; k++) begin
            checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL drain_data got=%h exp=%h", out_data, exp_q[0]); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(i) || out_data !== exp_q[0]) begin failures++; $display("FAIL stream[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, i); end
            checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL stream_end got=%b/%h exp=0/0", out_valid, out_data); end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA; step();
        in_data = 32'hB; step();
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2 || out_data !== 32'hA || in_ready !== 1'b0) begin failures++; $display("FAIL full got=%0d/%h/%b exp=2/a/0", occupancy, out_data, in_ready); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_data !== 32'hB || out_data !== exp_q[0]) begin failures++; $display("FAIL full_pop_data got=%h exp=b", out_data); end
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL full_pop_state got=%0d/%b exp=1/1", occupancy, in_ready); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 32'hC; step();
        flush = 1'b1; in_data = 32'hBAD0_0BAD; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_occ got=%0d/%b exp=0/0", occupancy, out_valid); end
        checks++; if (out_data !== 32'h0 || out_data2 !== NOP2) begin failures++; $display("FAIL flush_nop got=%h/%h exp=0/%h", out_data, out_data2, NOP2); end
        checks++; if (drop_cnt !== 16'(mdrop) || mdrop != 2) begin failures++; $display("FAIL flush_drop got=%0d exp=%0d", drop_cnt, mdrop); end
        checks++; if (drop_cnt2 !== 2'(sat(mdrop, 3))) begin failures++; $display("FAIL flush_drop2 got=%0d exp=%0d", drop_cnt2, sat(mdrop, 3)); end
        out_ready = 1'b1;
        repeat (3) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak got=%b/%h exp=0", out_valid, out_data); end
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; step();
        bubble = 1'b1; in_data = 32'h66; out_ready = 1'b1;
        checks++; if (out_data !== 32'h55) begin failures++; $display("FAIL bubble_head got=%h exp=55", out_data); end
        repeat (4) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bubble_in_ready got=%b exp=0", in_ready); end
            step();
        end
        bubble = 1'b0; in_valid = 1'b0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL bubble_drain got=%0d/%b exp=0/0", occupancy, out_valid); end
        checks++; if (bubble_cnt !== 16'(mbub) || mbub != 4) begin failures++; $display("FAIL bubble_cnt got=%0d exp=%0d", bubble_cnt, mbub); end
        checks++; if (bubble_cnt2 !== 2'(sat(mbub, 3))) begin failures++; $display("FAIL bubble_cnt2 got=%0d exp=%0d", bubble_cnt2, sat(mbub, 3)); end
    endtask

    task automatic test_sat_reset();
        test_reset();
        bubble = 1'b1;
        repeat (6) step();
        bubble = 1'b0;
        checks++; if (bubble_cnt !== 16'(mbub)) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=%0d", bubble_cnt, mbub); end
        checks++; if (bubble_cnt2 !== 2'(sat(mbub, 3)) || bubble_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_cnt2 got=%0d exp=3", bubble_cnt2); end
        in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h99;
        step(); step();
        in_valid = 1'b0;
        #1;
        RST = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0) begin failures++; $display("FAIL async_rst got=%b/%0d/%h exp=0/0/0", out_valid, occupancy, out_data); end
        checks++; if (bubble_cnt !== 16'd0 || drop_cnt !== 16'd0 || bubble_cnt2 !== 2'd0) begin failures++; $display("FAIL async_rst_cnt got=%0d/%0d/%0d exp=0/0/0", bubble_cnt, drop_cnt, bubble_cnt2); end
        checks++; if (out_data2 !== NOP2) begin failures++; $display("FAIL async_rst_nop2 got=%h exp=%h", out_data2, NOP2); end
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_q.delete(); mbub = 0; mdrop = 0;
        step();
        checks++; if (drop_cnt !== 16'd0 || occupancy !== 2'd0) begin failures++; $display("FAIL post_rst got=%0d/%0d exp=0/0", drop_cnt, occupancy); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_streaming();
        test_full_pop();
        test_flush();
        test_bubble();
        test_sat_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
